// File: rtl/uart_pkg.sv
// Shared UART constants and the encoding of the transmit-arbiter state machine.
package uart_pkg;

    localparam int CLOCK_FREQ = 32'd50_000_000;
    localparam int BAUD_RATE  = 32'd9600;
    localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;

    // 23 baud periods rounded up to the next 10k clocks: 120000 at 50 MHz / 9600 baud
    localparam int DEFAULT_TIMEOUT_CYCLES =
        ((32'd23 * BAUD_COUNT + 32'd9999) / 32'd10000) * 32'd10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first requester at or after last_id+1, wrapping.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [ID_W-1:0] idx_s;
    logic            hit_s;

    // Scan from the farthest offset down so the nearest requester after last_id wins
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx_s  = '0;
        hit_s  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s  = ID_W'((int'(last_id) + k) % NUM_REQ);
            hit_s  = req[idx_s];
            any    = any | hit_s;
            winner = hit_s ? idx_s : winner;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared 8N1 transmitter: grant, hold the frame, wait for
// completion or watchdog abort, then an optional idle gap before the next grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id,
    output logic                       frame_done,
    output logic                       timeout_err
);

    localparam int                  ID_W      = $clog2(NUM_REQ);
    localparam int                  WD_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]     WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]         GAP_LOAD  = 16'(GAP_CYCLES - 1);
    localparam bit                  HAS_GAP   = (GAP_CYCLES != 0);
    localparam logic [ID_W-1:0]     LAST_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  ACK_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t      state_r, state_next_s, after_frame_s;
    logic [ID_W-1:0] last_id_r;
    logic [ID_W-1:0] winner_s;
    logic            any_s;
    logic            grant_s, done_s, abort_s;
    logic [WD_W-1:0] wd_r;
    logic [15:0]     gap_r;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req     (req_valid),
        .last_id (last_id_r),
        .any     (any_s),
        .winner  (winner_s)
    );

    assign after_frame_s = HAS_GAP ? ST_GAP : ST_IDLE;

    // Next-state and event decode; tx_done takes priority over watchdog expiry
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    done_s       = 1'b1;
                    state_next_s = after_frame_s;
                end else if (wd_r == WD_LAST) begin
                    abort_s      = 1'b1;
                    state_next_s = after_frame_s;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_r == 16'd0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered transmitter interface, acknowledge and status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            req_ack     <= '0;
            busy        <= 1'b0;
            cur_id      <= '0;
            last_id_r   <= LAST_INIT;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_ack     <= grant_s ? (ACK_ONE << winner_s) : '0;
            frame_done  <= done_s;
            timeout_err <= abort_s;
            busy        <= (state_next_s != ST_IDLE);
            if (grant_s) begin
                tx_start  <= 1'b1;
                tx_data   <= req_data[{winner_s, 3'b000} +: 8];
                cur_id    <= winner_s;
                last_id_r <= winner_s;
            end else if (done_s || abort_s) begin
                tx_start  <= 1'b0;
            end
        end
    end

    // Watchdog and gap counter; both saturate at their terminal value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_r  <= '0;
            gap_r <= 16'd0;
        end else begin
            if (grant_s) begin
                wd_r <= '0;
            end else if (state_r == ST_SEND && wd_r != WD_LAST) begin
                wd_r <= wd_r + WD_W'(1);
            end
            if (done_s || abort_s) begin
                gap_r <= GAP_LOAD;
            end else if (state_r == ST_GAP && gap_r != 16'd0) begin
                gap_r <= gap_r - 16'd1;
            end
        end
    end

endmodule
